bullet_pool: RTL and testbench



---
 rtl/bullet_pkg.sv | 34 +++
 rtl/hit_fifo.sv | 53 +++++
 rtl/bullet_pool.sv | 198 +++++++++++++++++++
 tb/tb_bullet_pool.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// bullet_pkg: shared constants, hit-entry layout and the brick-cell index helper
// for the laser bullet pool. Cell geometry is 32x20 px, 3 bits per cell.
// No ports; imported by bullet_pool and hit_fifo users.
package bullet_pkg;

  localparam int CELL_W          = 32;
  localparam int CELL_H          = 20;
  localparam int BALL_BRICK_BITS = 3;
  localparam int BULLET_W        = 16;  // sprite width; right probe sits at x+16
  localparam int HIT_W           = 11;

  // Slot state is a single flag per slot.
  localparam logic SLOT_IDLE = 1'b0;
  localparam logic SLOT_FLY  = 1'b1;

  typedef struct packed {
    logic [8:0] idx;   // left brick cell
    logic [1:0] mask;  // [0] clears idx, [1] clears idx+1
  } hit_t;

  typedef struct packed {
    logic       oor;   // cell lies outside the grid
    logic [8:0] idx;
  } cell_t;

  function automatic cell_t cell_index(input int col, input int row,
                                       input int cols, input int rows);
    cell_t c;
    c.oor = (col >= cols) || (row >= rows);
    c.idx = 9'(col + cols * row);
    return c;
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// hit_fifo: synchronous FIFO carrying brick-clear requests; push/pop in the same
// cycle is allowed even when full. Latency: a pushed entry is visible next cycle.
// Ports: push_i/push_dat_i write, pop_i/pop_dat_o read head, full_o/empty_o status.
module hit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk_22,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == FULL_CNT);
  assign do_pop    = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push   = push_i & (~full_o | do_pop);
  assign pop_dat_o = mem_q[rd_q];

  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_22) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: pooled laser bullets; periodic volleys from the paddle, per-tick
// motion, brick probing and back-pressured hit requests (hit_valid/hit_ready).
// Ports: enable/run/board_x/board_w/bricks in; bullet_x/y/active, fire,
// fire_drop, hit_valid/idx/mask out. All outputs registered; a hit probed in
// tick T is visible from T+1. Losing or blocked bullets stall in place.
// Macro BULLET_PIERCE_EN: an accepted hit does not kill the bullet.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int N_BULLETS   = 4,
  parameter int COORD_W     = 10,
  parameter int BULLET_V    = 15,
  parameter int FIRE_PERIOD = 40,
  parameter int LAUNCH_Y    = 450,
  parameter int PARK_Y      = 700,
  parameter int HIT_DEPTH   = 4,
  parameter int BRICK_COLS  = 20,
  parameter int BRICK_ROWS  = 24
) (
  input  logic                                           clk_22,
  input  logic                                           rst,
  input  logic                                           enable,
  input  logic                                           run,
  input  logic [COORD_W-1:0]                             board_x,
  input  logic [COORD_W-1:0]                             board_w,
  input  logic [BALL_BRICK_BITS*BRICK_COLS*BRICK_ROWS-1:0] bricks,
  output logic [N_BULLETS*COORD_W-1:0]                   bullet_x,
  output logic [N_BULLETS*COORD_W-1:0]                   bullet_y,
  output logic [N_BULLETS-1:0]                           bullet_active,
  output logic                                           fire,
  output logic                                           fire_drop,
  output logic                                           hit_valid,
  output logic [8:0]                                     hit_idx,
  output logic [1:0]                                     hit_mask,
  input  logic                                           hit_ready
);

  localparam int MAP_W = BALL_BRICK_BITS * BRICK_COLS * BRICK_ROWS;
  localparam int CNT_W = $clog2(FIRE_PERIOD + 1);
  localparam logic [COORD_W-1:0] V_C      = COORD_W'(BULLET_V);
  localparam logic [COORD_W-1:0] LAUNCH_C = COORD_W'(LAUNCH_Y);
  localparam logic [COORD_W-1:0] PARK_C   = COORD_W'(PARK_Y);
  localparam logic [COORD_W-1:0] BW_C     = COORD_W'(BULLET_W);
  localparam logic [CNT_W-1:0]   LAST_C   = CNT_W'(FIRE_PERIOD - 1);

  logic [N_BULLETS-1:0] act_q, act_d;
  logic [COORD_W-1:0]   x_q [N_BULLETS];
  logic [COORD_W-1:0]   x_d [N_BULLETS];
  logic [COORD_W-1:0]   y_q [N_BULLETS];
  logic [COORD_W-1:0]   y_d [N_BULLETS];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fire_q, fire_d, drop_q, drop_d;
  logic [HIT_W:0]       probe_res [N_BULLETS];  // {hit, hit_t}
  logic                 push, push_ok, won, fifo_full, fifo_empty;
  logic [1:0]           nlaunch;
  hit_t                 push_dat, pop_dat;

  // Probe the two cells under the bullet's next position. The right edge is
  // computed one bit wider so x near the top of the range does not wrap.
  function automatic logic [HIT_W:0] probe(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] ny,
                                           input logic [MAP_W-1:0]   map);
    logic [COORD_W:0]           xr;
    cell_t                      cl, cr;
    logic [BALL_BRICK_BITS-1:0] vl, vr;
    logic                       same;
    hit_t                       h;
    xr   = {1'b0, x} + {1'b0, BW_C};
    same = (int'(x) / CELL_W) == (int'(xr) / CELL_W);
    cl   = cell_index(int'(x) / CELL_W, int'(ny) / CELL_H, BRICK_COLS, BRICK_ROWS);
    cr   = cell_index(int'(xr) / CELL_W, int'(ny) / CELL_H, BRICK_COLS, BRICK_ROWS);
    vl   = cl.oor ? '0 : map[int'(cl.idx) * BALL_BRICK_BITS +: BALL_BRICK_BITS];
    vr   = cr.oor ? '0 : map[int'(cr.idx) * BALL_BRICK_BITS +: BALL_BRICK_BITS];
    h.idx  = cl.idx;
    h.mask = same ? {1'b0, |vl} : {|vr, |vl};
    return {|h.mask, h};
  endfunction

  always_comb begin
    for (int k = 0; k < N_BULLETS; k++) begin
      probe_res[k] = probe(x_q[k], y_q[k] - V_C, bricks);
    end
  end

  assign hit_valid = ~fifo_empty;
  assign push_ok   = ~fifo_full | (hit_valid & hit_ready);

  always_comb begin
    act_d    = act_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    fire_d   = 1'b0;
    drop_d   = 1'b0;
    push     = 1'b0;
    push_dat = '0;
    won      = 1'b0;
    nlaunch  = 2'd0;
    if (!enable) begin
      cnt_d = '0;
      for (int k = 0; k < N_BULLETS; k++) begin
        act_d[k] = SLOT_IDLE;
        x_d[k]   = '0;
        y_d[k]   = PARK_C;
      end
    end else if (run) begin
      cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
      for (int k = 0; k < N_BULLETS; k++) begin
        if (act_q[k] == SLOT_FLY) begin
          if (y_q[k] < V_C) begin
            act_d[k] = SLOT_IDLE;
            x_d[k]   = '0;
            y_d[k]   = PARK_C;
          end else if (!probe_res[k][HIT_W]) begin
            y_d[k] = y_q[k] - V_C;
          end else if (!won) begin
            // First hitting slot owns the single push; later hitters stall.
            won      = 1'b1;
            push     = 1'b1;
            push_dat = probe_res[k][HIT_W-1:0];
            if (push_ok) begin
`ifdef BULLET_PIERCE_EN
              y_d[k] = y_q[k] - V_C;
`else
              act_d[k] = SLOT_IDLE;
              x_d[k]   = '0;
              y_d[k]   = PARK_C;
`endif
            end
          end
        end
      end
      // Volley uses slots idle at the start of the tick.
      if (cnt_q == '0) begin
        for (int k = 0; k < N_BULLETS; k++) begin
          if (act_q[k] == SLOT_IDLE && nlaunch != 2'd2) begin
            act_d[k] = SLOT_FLY;
            x_d[k]   = (nlaunch == 2'd0) ? board_x : board_x + board_w - BW_C;
            y_d[k]   = LAUNCH_C;
            nlaunch  = nlaunch + 2'd1;
          end
        end
        fire_d = (nlaunch != 2'd0);
        drop_d = (nlaunch == 2'd0);
      end
    end
  end

  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      act_q  <= '0;
      cnt_q  <= '0;
      fire_q <= 1'b0;
      drop_q <= 1'b0;
      for (int k = 0; k < N_BULLETS; k++) begin
        x_q[k] <= '0;
        y_q[k] <= PARK_C;
      end
    end else begin
      act_q  <= act_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      fire_q <= fire_d;
      drop_q <= drop_d;
    end
  end

  hit_fifo #(
    .DEPTH (HIT_DEPTH),
    .WIDTH (HIT_W)
  ) u_hit_fifo (
    .clk_22     (clk_22),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (hit_ready),
    .pop_dat_o  (pop_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    bullet_x = '0;
    bullet_y = '0;
    for (int k = 0; k < N_BULLETS; k++) begin
      bullet_x[k*COORD_W +: COORD_W] = x_q[k];
      bullet_y[k*COORD_W +: COORD_W] = y_q[k];
    end
  end

  assign bullet_active = act_q;
  assign fire          = fire_q;
  assign fire_drop     = drop_q;
  assign hit_idx       = pop_dat.idx;
  assign hit_mask      = pop_dat.mask;

endmodule

// File: tb/tb_bullet_pool.sv
module tb_bullet_pool;

  localparam int N = 4, CW = 10, V = 15, FP = 40, LY = 450, PY = 700, HD = 4;
  localparam int COLS = 20, ROWS = 24, NCELL = COLS * ROWS;
`ifdef BULLET_PIERCE_EN
  localparam bit PIERCE = 1'b1;
`else
  localparam bit PIERCE = 1'b0;
`endif

  logic              clk_22 = 1'b0, rst = 1'b0;
  logic              enable = 1'b0, run = 1'b0, hit_ready = 1'b0;
  logic [CW-1:0]     board_x = '0, board_w = 10'd16;
  logic [3*NCELL-1:0] bricks = '0;
  logic [N*CW-1:0]   bullet_x, bullet_y;
  logic [N-1:0]      bullet_active;
  logic              fire, fire_drop, hit_valid;
  logic [8:0]        hit_idx;
  logic [1:0]        hit_mask;

  int bmap [NCELL];
  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit m_act [N];
  int m_x [N], m_y [N];
  int m_cnt;
  bit m_fire, m_drop;
  int q_idx [$];
  int q_mask [$];

  bullet_pool #(
    .N_BULLETS(N), .COORD_W(CW), .BULLET_V(V), .FIRE_PERIOD(FP), .LAUNCH_Y(LY),
    .PARK_Y(PY), .HIT_DEPTH(HD), .BRICK_COLS(COLS), .BRICK_ROWS(ROWS)
  ) dut (
    .clk_22(clk_22), .rst(rst), .enable(enable), .run(run),
    .board_x(board_x), .board_w(board_w), .bricks(bricks),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
    .fire(fire), .fire_drop(fire_drop), .hit_valid(hit_valid),
    .hit_idx(hit_idx), .hit_mask(hit_mask), .hit_ready(hit_ready)
  );

  always #5 clk_22 = ~clk_22;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int cell_val(input int col, input int row);
    if (col >= COLS || row >= ROWS) return 0;
    return bmap[col + COLS * row];
  endfunction

  task automatic park(input int k);
    m_act[k] = 1'b0;
    m_x[k]   = 0;
    m_y[k]   = PY;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) park(k);
    m_cnt = 0; m_fire = 1'b0; m_drop = 1'b0;
    q_idx.delete(); q_mask.delete();
  endtask

  task automatic model_step();
    bit pop, room, claimed, do_push;
    bit was [N];
    int ny, row, lc, rc, lv, rv, nl, p_idx, p_mask;
    pop     = (q_idx.size() > 0) && hit_ready;
    room    = (q_idx.size() < HD) || pop;
    do_push = 1'b0; p_idx = 0; p_mask = 0;
    m_fire  = 1'b0; m_drop = 1'b0;
    if (!enable) begin
      for (int k = 0; k < N; k++) park(k);
      m_cnt = 0;
    end else if (run) begin
      was = m_act;
      claimed = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (was[k]) begin
          if (m_y[k] < V) park(k);
          else begin
            ny  = m_y[k] - V;
            row = ny / 20;
            lc  = m_x[k] / 32;
            rc  = (m_x[k] + 16) / 32;
            lv  = cell_val(lc, row);
            rv  = cell_val(rc, row);
            if (lv == 0 && rv == 0) m_y[k] = ny;
            else if (!claimed) begin
              claimed = 1'b1;
              if (room) begin
                do_push = 1'b1;
                p_idx   = lc + COLS * row;
                p_mask  = (lc == rc) ? 1 : ((rv != 0) ? 2 : 0) + ((lv != 0) ? 1 : 0);
                if (PIERCE) m_y[k] = ny;
                else park(k);
              end
            end
          end
        end
      end
      if (m_cnt == 0) begin
        nl = 0;
        for (int k = 0; k < N; k++) begin
          if (!was[k] && nl < 2) begin
            m_act[k] = 1'b1;
            m_x[k]   = (nl == 0) ? int'(board_x) : (int'(board_x) + int'(board_w) - 16) & 1023;
            m_y[k]   = LY;
            nl++;
          end
        end
        if (nl > 0) m_fire = 1'b1;
        else m_drop = 1'b1;
      end
      m_cnt = (m_cnt + 1) % FP;
    end
    if (pop) begin
      void'(q_idx.pop_front());
      void'(q_mask.pop_front());
    end
    if (do_push) begin
      q_idx.push_back(p_idx);
      q_mask.push_back(p_mask);
    end
  endtask

  always @(posedge clk_22 or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_22) begin
    logic [N*CW-1:0] ex, ey;
    logic [N-1:0]    ea;
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        ea[k]          = m_act[k];
        ex[k*CW +: CW] = CW'(m_x[k]);
        ey[k*CW +: CW] = CW'(m_y[k]);
      end
      check("m_active", bullet_active, ea);
      check("m_x", bullet_x, ex);
      check("m_y", bullet_y, ey);
      check("m_fire", fire, m_fire);
      check("m_fire_drop", fire_drop, m_drop);
      check("m_hit_valid", hit_valid, q_idx.size() != 0);
      if (q_idx.size() != 0) begin
        check("m_hit_idx", hit_idx, q_idx[0]);
        check("m_hit_mask", hit_mask, q_mask[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_22);
  endtask

  task automatic set_map();
    for (int i = 0; i < NCELL; i++) bricks[3*i +: 3] = 3'(bmap[i]);
  endtask

  task automatic clear_map();
    for (int i = 0; i < NCELL; i++) bmap[i] = 0;
  endtask

  initial begin
    clear_map();
    set_map();
    #1 rst = 1'b1;
    #2;
    check("rst_active", bullet_active, 0);
    check("rst_y0", bullet_y[0 +: CW], 700);
    check("rst_x1", bullet_x[CW +: CW], 0);
    check("rst_hit_valid", hit_valid, 0);
    check("rst_fire", fire, 0);
    chk_en = 1'b1;
    @(negedge clk_22);
    rst = 1'b0;

    // Volley timing on an empty map
    board_x = 10'd100; board_w = 10'd96; hit_ready = 1'b1; enable = 1'b1; run = 1'b1;
    tick(1);
    check("a_fire", fire, 1);
    check("a_x0", bullet_x[0 +: CW], 100);
    check("a_x1", bullet_x[CW +: CW], 180);
    check("a_y0", bullet_y[0 +: CW], 450);
    check("a_y1", bullet_y[CW +: CW], 450);
    check("a_active", bullet_active, 4'b0011);
    tick(30);
    check("a_y0_top", bullet_y[0 +: CW], 0);
    check("a_active_top", bullet_active, 4'b0011);
    tick(1);
    check("a_gone", bullet_active, 0);
    check("a_park_y", bullet_y[0 +: CW], 700);
    tick(8);
    check("a_no_fire_t40", fire, 0);
    tick(1);
    check("a_fire_t41", fire, 1);

    // Single-cell hit
    enable = 1'b0;
    tick(1);
    bmap[205] = 3; set_map();
    board_x = 10'd160; board_w = 10'd400; hit_ready = 1'b0; enable = 1'b1;
    tick(16);
    check("b_y_before", bullet_y[0 +: CW], 225);
    tick(1);
    check("b_hit_valid", hit_valid, 1);
    check("b_hit_idx", hit_idx, 205);
    check("b_hit_mask", hit_mask, 1);
    check("b_slot0", bullet_active[0], PIERCE);

    // Bullet spanning two filled cells
    enable = 1'b0; hit_ready = 1'b1;
    tick(1);
    bmap[206] = 2; set_map();
    board_x = 10'd176; hit_ready = 1'b0; enable = 1'b1;
    tick(17);
    check("c_hit_idx", hit_idx, 205);
    check("c_hit_mask", hit_mask, 3);

    // Fill FIFO, stall everything, exhaust slots
    enable = 1'b0; hit_ready = 1'b1;
    tick(1);
    clear_map();
    for (int c = 0; c < COLS; c++) bmap[200 + c] = 1;
    set_map();
    board_x = 10'd160; board_w = 10'd400; hit_ready = 1'b0; enable = 1'b1;
    tick(160);
    check("d_stall_y0", bullet_y[0 +: CW], 225);
    tick(1);
    check("d_fire_drop", fire_drop, 1);
    check("d_no_fire", fire, 0);
    check("d_all_live", bullet_active, 4'hF);
    check("d_stall_y3", bullet_y[3*CW +: CW], 225);
    hit_ready = 1'b1;
    tick(1);
    check("d_push_on_pop", bullet_active, PIERCE ? 4'hF : 4'hE);
    check("d_y0_after", bullet_y[0 +: CW], PIERCE ? 210 : 700);

    // Drop enable mid-flight
    enable = 1'b0;
    tick(1);
    check("e_active", bullet_active, 0);
    check("e_park_y", bullet_y[0 +: CW], 700);
    check("e_drain", hit_valid, 1);

    // Asynchronous reset mid-flight
    enable = 1'b1;
    tick(5);
    check("f_live", bullet_active, 4'b0011);
    #2 rst = 1'b1;
    #1;
    check("f_active", bullet_active, 0);
    check("f_y0", bullet_y[0 +: CW], 700);
    check("f_x0", bullet_x[0 +: CW], 0);
    check("f_hit_valid", hit_valid, 0);
    check("f_fire", fire, 0);
    @(negedge clk_22);
    rst = 1'b0;

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) begin
        for (int i = 0; i < NCELL; i++)
          bmap[i] = ($urandom % 12 == 0) ? int'($urandom_range(1, 7)) : 0;
        set_map();
        board_x = CW'($urandom_range(0, 900));
        board_w = CW'($urandom_range(16, 120));
      end
      if ($urandom % 50 == 0) board_x = CW'($urandom_range(0, 900));
      enable    = ($urandom % 150) != 0;
      run       = ($urandom % 12) != 0;
      hit_ready = ($urandom % 3) != 0;
      tick(1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
